// File: rtl/output_credit_unit_if.sv
// -----------------------------------------------------------------------------
// output_credit_unit_if
// Bundle of the signals exchanged between an output_credit_unit and its
// surroundings (crossbar lane in, credit return in, registered link out,
// status out).
//
// Modports:
//   slave  - the output_credit_unit itself
//   master - whatever drives the lane/credits and observes the link
//
// Signals:
//   in_data / in_valid            crossbar lane flit, no backpressure
//   credit_in_valid / credit_in_vc credit returned by the downstream router
//   link_data / link_vc / link_valid registered flit towards downstream
//   vc_availability               one bit per downstream VC, set when credit != 0
//   fifo_count                    skid FIFO occupancy
//   overflow_err / credit_err     sticky error flags
// -----------------------------------------------------------------------------
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

interface output_credit_unit_if #(
  parameter int NUM_VC     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int VC_BITS    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  parameter int CNT_BITS   = $clog2(FIFO_DEPTH + 1)
);

  logic [`FLIT_DATA_WIDTH-1:0] in_data;
  logic                        in_valid;
  logic                        credit_in_valid;
  logic [VC_BITS-1:0]          credit_in_vc;
  logic [`FLIT_DATA_WIDTH-1:0] link_data;
  logic [VC_BITS-1:0]          link_vc;
  logic                        link_valid;
  logic [NUM_VC-1:0]           vc_availability;
  logic [CNT_BITS-1:0]         fifo_count;
  logic                        overflow_err;
  logic                        credit_err;

  modport slave (
    input  in_data, in_valid, credit_in_valid, credit_in_vc,
    output link_data, link_vc, link_valid, vc_availability,
           fifo_count, overflow_err, credit_err
  );

  modport master (
    output in_data, in_valid, credit_in_valid, credit_in_vc,
    input  link_data, link_vc, link_valid, vc_availability,
           fifo_count, overflow_err, credit_err
  );

endinterface

// File: rtl/output_credit_unit.sv
// -----------------------------------------------------------------------------
// output_credit_unit
// Per-output-port stage behind the router crossbar. Flits from one crossbar
// lane land in a small skid FIFO; the head is sent on the registered link to
// a downstream VC picked round-robin among VCs that still hold credits. The
// downstream router hands credits back one at a time on credit_in_*.
//
// Ports:
//   clk    - clock, all state changes on posedge
//   reset  - synchronous, active-high
//   bus    - output_credit_unit_if.slave (lane in, credit in, link out,
//            vc_availability, fifo_count, sticky overflow/credit errors)
//
// FIFO_DEPTH must be a power of two: head/tail wrap by natural overflow and
// the occupancy counter alone tells full from empty.
// -----------------------------------------------------------------------------
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

module output_credit_unit #(
  parameter int NUM_VC     = 4,
  parameter int BUF_DEPTH  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  output_credit_unit_if.slave    bus
);

  localparam int VC_BITS     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int CREDIT_BITS = $clog2(BUF_DEPTH + 1);
  localparam int CNT_BITS    = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_BITS    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef logic [`FLIT_DATA_WIDTH-1:0] flit_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  flit_t                  fifo_mem [FIFO_DEPTH];
  logic [PTR_BITS-1:0]    head;
  logic [PTR_BITS-1:0]    tail;
  logic [CNT_BITS-1:0]    count;

  logic [CREDIT_BITS-1:0] credit [NUM_VC];
  logic [VC_BITS-1:0]     rr_ptr;

  flit_t                  link_data_q;
  logic [VC_BITS-1:0]     link_vc_q;
  logic                   link_valid_q;
  logic                   overflow_err_q;
  logic                   credit_err_q;

  // ---------------------------------------------------------------------------
  // Round-robin VC selection among VCs with credits
  // ---------------------------------------------------------------------------
  logic [VC_BITS:0]       scan_idx;
  logic [VC_BITS-1:0]     sel;
  logic                   sel_found;

  // Scan offsets from the far end back to rr_ptr so the last hit is the one
  // closest to rr_ptr, i.e. the first VC in round-robin order.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    scan_idx  = '0;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      scan_idx = {1'b0, rr_ptr} + (VC_BITS + 1)'(i);
      if (scan_idx >= (VC_BITS + 1)'(NUM_VC)) begin
        scan_idx = scan_idx - (VC_BITS + 1)'(NUM_VC);
      end
      if (credit[scan_idx[VC_BITS-1:0]] != '0) begin
        sel       = scan_idx[VC_BITS-1:0];
        sel_found = 1'b1;
      end
    end
  end

  logic [VC_BITS-1:0] sel_next;
  assign sel_next = (sel == VC_BITS'(NUM_VC - 1)) ? '0 : sel + VC_BITS'(1);

  // ---------------------------------------------------------------------------
  // FIFO push/pop decisions
  // ---------------------------------------------------------------------------
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push_ok;
  logic push_drop;
  logic [CNT_BITS-1:0] count_next;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_BITS'(FIFO_DEPTH));
  assign pop        = !fifo_empty && sel_found;
  // A full FIFO still takes a flit when the head leaves on the same edge.
  assign push_ok    = bus.in_valid && (!fifo_full || pop);
  assign push_drop  = bus.in_valid && fifo_full && !pop;
  assign count_next = count + CNT_BITS'(push_ok) - CNT_BITS'(pop);

  // ---------------------------------------------------------------------------
  // Per-VC credit increment/decrement terms
  // ---------------------------------------------------------------------------
  logic [NUM_VC-1:0] credit_inc;
  logic [NUM_VC-1:0] credit_dec;
  logic [NUM_VC-1:0] credit_at_max;
  logic              credit_overrun;

  always_comb begin
    credit_inc    = '0;
    credit_dec    = '0;
    credit_at_max = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      credit_inc[v]    = bus.credit_in_valid && (bus.credit_in_vc == VC_BITS'(v));
      credit_dec[v]    = pop && (sel == VC_BITS'(v));
      credit_at_max[v] = (credit[v] == CREDIT_BITS'(BUF_DEPTH));
    end
  end

  // A return matched by a same-VC dispatch nets out and is never an overrun.
  assign credit_overrun = |(credit_inc & ~credit_dec & credit_at_max);

  // ---------------------------------------------------------------------------
  // Sequential update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      rr_ptr         <= '0;
      link_data_q    <= '0;
      link_vc_q      <= '0;
      link_valid_q   <= 1'b0;
      overflow_err_q <= 1'b0;
      credit_err_q   <= 1'b0;
      for (int v = 0; v < NUM_VC; v++) begin
        credit[v] <= CREDIT_BITS'(BUF_DEPTH);
      end
    end else begin
      if (push_ok) begin
        fifo_mem[tail] <= bus.in_data;
        tail           <= tail + PTR_BITS'(1);
      end

      if (pop) begin
        head         <= head + PTR_BITS'(1);
        link_data_q  <= fifo_mem[head];
        link_vc_q    <= sel;
        link_valid_q <= 1'b1;
        rr_ptr       <= sel_next;
      end else begin
        link_valid_q <= 1'b0;
      end

      count <= count_next;

      for (int v = 0; v < NUM_VC; v++) begin
        if (credit_dec[v] && !credit_inc[v]) begin
          credit[v] <= credit[v] - CREDIT_BITS'(1);
        end else if (credit_inc[v] && !credit_dec[v] && !credit_at_max[v]) begin
          credit[v] <= credit[v] + CREDIT_BITS'(1);
        end
      end

      if (push_drop) begin
        overflow_err_q <= 1'b1;
      end
      if (credit_overrun) begin
        credit_err_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.vc_availability = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      bus.vc_availability[v] = (credit[v] != '0);
    end
  end

  assign bus.link_data    = link_data_q;
  assign bus.link_vc      = link_vc_q;
  assign bus.link_valid   = link_valid_q;
  assign bus.fifo_count   = count;
  assign bus.overflow_err = overflow_err_q;
  assign bus.credit_err   = credit_err_q;

endmodule

// File: tb/tb_output_credit_unit.sv
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

module tb_output_credit_unit;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  output_credit_unit_if #(.NUM_VC(4), .FIFO_DEPTH(4)) bus ();

  output_credit_unit #(
    .NUM_VC    (4),
    .BUF_DEPTH (2),
    .FIFO_DEPTH(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [`FLIT_DATA_WIDTH-1:0] data;
    logic [1:0]                  vc;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then sample; any link flit is matched against the scoreboard.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.link_valid === 1'b1) begin
      vectors++;
      assert (sb.size() != 0)
      else begin
        miscompares++;
        $error("FAIL unexpected_flit: observed data 0x%0h vc %0d, expected no flit",
               bus.link_data, bus.link_vc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("link_data", 64'(bus.link_data), 64'(e.data));
        check("link_vc", 64'(bus.link_vc), 64'(e.vc));
      end
    end
  endtask

  task automatic do_reset();
    reset               = 1'b1;
    bus.in_valid        = 1'b0;
    bus.credit_in_valid = 1'b0;
    sb.delete();
    cycle();
    reset = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input bit track, input logic [1:0] vc);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    if (track) sb.push_back('{d, vc});
    cycle();
    bus.in_valid = 1'b0;
  endtask

  task automatic give_credit(input logic [1:0] vc);
    bus.credit_in_valid = 1'b1;
    bus.credit_in_vc    = vc;
    cycle();
    bus.credit_in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset               = 1'b1;
    bus.in_data         = '0;
    bus.in_valid        = 1'b0;
    bus.credit_in_valid = 1'b0;
    bus.credit_in_vc    = '0;

    // 1. reset state, single flit latency
    do_reset();
    check("t1_avail_reset", 64'(bus.vc_availability), 64'(4'b1111));
    check("t1_valid_reset", 64'(bus.link_valid), 64'(0));
    check("t1_count_reset", 64'(bus.fifo_count), 64'(0));
    send(32'hA5, 1'b1, 2'd0);
    check("t1_valid_after_push", 64'(bus.link_valid), 64'(0));
    check("t1_count_after_push", 64'(bus.fifo_count), 64'(1));
    cycle();
    check("t1_sb_drained", 64'(sb.size()), 64'(0));
    check("t1_credit0", 64'(dut.credit[0]), 64'(1));
    cycle();
    check("t1_valid_idle", 64'(bus.link_valid), 64'(0));

    // 2. five back-to-back flits, round-robin 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 5; i++) send(32'h10 + 32'(i), 1'b1, 2'(i % 4));
    cycle();
    check("t2_sb_drained", 64'(sb.size()), 64'(0));
    check("t2_avail", 64'(bus.vc_availability), 64'(4'b1110));

    // 3. ten flits, credits run out after eight
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 8)       send(32'h30 + 32'(i), 1'b1, 2'(i % 4));
      else if (i == 8) send(32'h30 + 32'(i), 1'b1, 2'd2);
      else             send(32'h30 + 32'(i), 1'b0, 2'd0);
    end
    check("t3_count_stalled", 64'(bus.fifo_count), 64'(2));
    check("t3_valid_stalled", 64'(bus.link_valid), 64'(0));
    check("t3_avail_empty", 64'(bus.vc_availability), 64'(4'b0000));
    check("t3_sb_pending", 64'(sb.size()), 64'(1));
    give_credit(2'd2);
    check("t3_valid_credit_edge", 64'(bus.link_valid), 64'(0));
    cycle();
    check("t3_sb_drained", 64'(sb.size()), 64'(0));
    check("t3_count_after", 64'(bus.fifo_count), 64'(1));

    // 4. credit return and dispatch on the same VC in the same cycle
    do_reset();
    for (int i = 0; i < 6; i++) send(32'h50 + 32'(i), 1'b1, 2'(i % 4));
    give_credit(2'd1);
    check("t4_sb_drained", 64'(sb.size()), 64'(0));
    check("t4_credit1", 64'(dut.credit[1]), 64'(1));
    check("t4_avail1", 64'(bus.vc_availability[1]), 64'(1));
    check("t4_credit_err", 64'(bus.credit_err), 64'(0));

    // 5. credit returned to a full VC
    do_reset();
    give_credit(2'd3);
    check("t5_credit3", 64'(dut.credit[3]), 64'(2));
    check("t5_credit_err", 64'(bus.credit_err), 64'(1));
    for (int i = 0; i < 3; i++) cycle();
    check("t5_credit_err_sticky", 64'(bus.credit_err), 64'(1));

    // 6. overflow with no credits, then reset during traffic
    do_reset();
    check("t6_credit_err_cleared", 64'(bus.credit_err), 64'(0));
    for (int i = 0; i < 8; i++) send(32'h70 + 32'(i), 1'b1, 2'(i % 4));
    cycle();
    cycle();
    check("t6_sb_drained_first", 64'(sb.size()), 64'(0));
    check("t6_avail_none", 64'(bus.vc_availability), 64'(4'b0000));
    for (int i = 0; i < 4; i++) send(32'hC0 + 32'(i), 1'b1, 2'(i));
    check("t6_count_full", 64'(bus.fifo_count), 64'(4));
    check("t6_no_overflow_yet", 64'(bus.overflow_err), 64'(0));
    send(32'hEE, 1'b0, 2'd0);
    check("t6_overflow", 64'(bus.overflow_err), 64'(1));
    check("t6_count_after_drop", 64'(bus.fifo_count), 64'(4));
    for (int v = 0; v < 4; v++) give_credit(2'(v));
    for (int i = 0; i < 3; i++) cycle();
    check("t6_sb_drained_second", 64'(sb.size()), 64'(0));
    check("t6_count_empty", 64'(bus.fifo_count), 64'(0));
    send(32'h77, 1'b0, 2'd0);
    send(32'h78, 1'b0, 2'd0);
    check("t6_count_queued", 64'(bus.fifo_count), 64'(2));
    do_reset();
    check("t6_count_reset", 64'(bus.fifo_count), 64'(0));
    check("t6_overflow_reset", 64'(bus.overflow_err), 64'(0));
    check("t6_credit_err_reset", 64'(bus.credit_err), 64'(0));
    check("t6_avail_reset", 64'(bus.vc_availability), 64'(4'b1111));
    check("t6_valid_reset", 64'(bus.link_valid), 64'(0));
    check("t6_data_reset", 64'(bus.link_data), 64'(0));
    check("t6_vc_reset", 64'(bus.link_vc), 64'(0));
    for (int i = 0; i < 3; i++) cycle();
    check("t6_count_stays_empty", 64'(bus.fifo_count), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/output_credit_unit.md
Name: output_credit_unit

Overview:
Per-output-port stage downstream of router_top. It consumes one crossbar output lane (out_data[p]/out_valid[p]) and buffers flits in a small skid FIFO. It picks a downstream VC round-robin among VCs with credits, drives the registered link, and tracks per-VC credits returned by the downstream router. Its vc_availability output feeds the matching NUM_VC-bit slice of router_top's vc_availability input. router_top instantiates it once per port.

Parameters:
NUM_VC, 4, number of downstream VCs on this link
BUF_DEPTH, 2, flit slots per downstream VC (initial credit count)
FIFO_DEPTH, 4, skid FIFO entries (power of 2)
VC_BITS, $clog2(NUM_VC), VC index width
CREDIT_BITS, $clog2(BUF_DEPTH+1), credit counter width
CNT_BITS, $clog2(FIFO_DEPTH+1), FIFO occupancy width

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
in_data  input  `FLIT_DATA_WIDTH  flit from crossbar lane
in_valid  input  1  in_data valid; no backpressure, so the push is unconditional
credit_in_valid  input  1  downstream freed one slot
credit_in_vc  input  VC_BITS  VC of returned credit
link_data  output  `FLIT_DATA_WIDTH  registered flit to downstream router
link_vc  output  VC_BITS  registered downstream VC of link_data
link_valid  output  1  registered link valid
vc_availability  output  NUM_VC  bit v = (credit[v] != 0)
fifo_count  output  CNT_BITS  skid FIFO occupancy
overflow_err  output  1  sticky: flit dropped, FIFO was full
credit_err  output  1  sticky: credit returned to a VC already at BUF_DEPTH

Behaviour:
- Reset (sync, active-high) puts the block in this state:
  - FIFO empty, fifo_count=0;
  - credit[v]=BUF_DEPTH for all v;
  - rr_ptr=0;
  - link_valid=0, link_data=0, link_vc=0;
  - both error flags cleared.
- Reset during traffic discards queued flits and restores this state on the same edge. All other inputs are ignored on that edge.
- vc_availability is combinational from the credit registers. With BUF_DEPTH>0 it is all-ones out of reset.
- Push: if in_valid, in_data is written at the tail.
  - If full and no pop this cycle, the flit is dropped and overflow_err is set.
  - Push while full with a pop in the same cycle is legal.
- Dispatch is evaluated each cycle when the FIFO is non-empty:
  - sel = first v scanning rr_ptr, rr_ptr+1, ... (mod NUM_VC) with credit[v]!=0.
  - If sel exists, the head pops. link_data<=head, link_vc<=sel, link_valid<=1, credit[sel] decrements, rr_ptr<=(sel+1) mod NUM_VC.
  - Otherwise link_valid<=0 and the head stays.
- No dispatch: link_valid<=0, and link_data/link_vc hold their values.
- Latency: a flit pushed at edge k is dispatched at edge k+1 when the FIFO was empty and a credit exists, so link_valid is high in the cycle after edge k+1. There is no bypass path.
- Throughput: one flit per cycle while credits last.
- Credit return: credit[credit_in_vc] increments.
  - Increment and dispatch decrement on the same VC in the same cycle: net unchanged.
  - Increment with credit already at BUF_DEPTH and no same-VC decrement: saturate at BUF_DEPTH and set credit_err.
- fifo_count = count + push_accepted - pop, updated every edge.
- The FIFO uses wrap-around head/tail pointers. The count alone distinguishes full from empty.
- Error flags clear only on reset.

Test Plan:
Defaults NUM_VC=4, BUF_DEPTH=2, FIFO_DEPTH=4.
1. Reset, then one flit 0xA5 in cycle 0 -> reset outputs are vc_availability=4'b1111 and link_valid=0. Then link_valid=1, link_data=0xA5, link_vc=0 in cycle 2, and credit[0]=1.
2. Five back-to-back flits -> link_vc sequence 0,1,2,3,0 on consecutive cycles, then vc_availability=4'b1110.
3. Ten back-to-back flits, no credit returns -> eight dispatched (two per VC) and vc_availability=4'b0000. fifo_count reaches 2 and link_valid drops. Then credit_in_vc=2 -> the next queued flit appears with link_vc=2 on the following cycle and fifo_count drops to 1.
4. Dispatch on VC1 (credit[1]=1) with credit_in_valid, credit_in_vc=1 in the same cycle -> credit[1] stays 1, vc_availability[1]=1, credit_err=0.
5. After reset, credit_in_valid with credit_in_vc=3 -> credit[3] stays 2 and credit_err=1, sticky until reset.
6. No credits, fill FIFO to 4, push a 5th -> overflow_err=1, fifo_count=4, dropped flit never appears. Then assert reset -> fifo_count=0, errors 0, vc_availability=4'b1111, link_valid=0.
